key_conditioner: RTL and testbench
==================================

# key_conditioner

Front-end conditioning stage for the 4-bit logic processor: takes the three raw, active-low, bouncing push-button inputs (LoadA, LoadB, Execute), synchronizes them to Clk, debounces them, and drives clean active-high levels plus one-cycle press pulses. Its level outputs feed the control state machine directly. That state machine treats LoadA/LoadB as levels and requires Execute to stay high until the run completes.

## Interface
- DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles needed to accept a change (10 ms at 50 MHz); legal range 2..2^24.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1), is the debounce counter width. It is derived and must not be overridden.

Ports, clock and reset first:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Key_n  input  3  raw buttons, active-low, asynchronous to Clk; bit 0 = LoadA, bit 1 = LoadB, bit 2 = Execute.
- LoadA  output  1  debounced level, high while the button is held.
- LoadB  output  1  debounced level.
- Execute  output  1  debounced level.
- Press  output  3  one-cycle pulse on each debounced rising edge; bit mapping as Key_n.

## Operation
- Each bit is processed by an independent, identical channel. There is no interaction between channels.
- Synchronizer: two flops per bit; the inverted raw input goes into sync1, then sync2. Both reset to 0 (released).
- Per-channel FSM states:
  - IDLE: stable released.
  - PRESS_CNT: candidate press.
  - HELD: stable pressed.
  - REL_CNT: candidate release.
- Transitions:
  - IDLE → PRESS_CNT when sync2=1; cnt loads 1.
  - PRESS_CNT: if sync2=0, go to IDLE and clear cnt. Else if cnt==DEBOUNCE_CYCLES-1, go to HELD and clear cnt. Else increment cnt.
  - HELD → REL_CNT when sync2=0; cnt loads 1.
  - REL_CNT: if sync2=1, go to HELD and clear cnt. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE and clear cnt. Else increment cnt.
- Level output is registered: high exactly when the state is HELD or REL_CNT.
- A bounce of any length shorter than DEBOUNCE_CYCLES never changes the level output. The counter restarts on every reversal.
- Press[i] is registered and high for exactly one cycle, on the edge where the channel enters HELD from PRESS_CNT. It is never asserted on REL_CNT→HELD.
- The counter saturates by construction: it never exceeds DEBOUNCE_CYCLES-1 and never wraps.

## Timing
- Reset values: LoadA=LoadB=Execute=0, Press=0, all states IDLE, all counters 0, sync flops 0.
- Latency: raw input held pressed from edge k gives sync2=1 at edge k+2. The level rises and Press pulses at edge k+1+DEBOUNCE_CYCLES+1, i.e. k+2+DEBOUNCE_CYCLES. Release timing is symmetric; there is no pulse on release.
- Reset mid-count: everything returns to its reset value immediately; the partial count is lost.
- Button held through Reset deassertion: it is treated as a fresh press and reaches the outputs after the full latency.
- Simultaneous presses on several keys are handled in parallel. Each channel has its own latency and no priority.

## Configuration
- Macro KEY_COND_DEBOUNCE_EN.
- Defined: full debounce as described above.
- Undefined: the counters and the CNT states are compiled out. Each level output is sync2 registered once, so the latency is 3 edges. Press still pulses for one cycle on a level rise. Reset values are unchanged. This mode is for fast simulation only.

## Structure
- Package key_cond_pkg holds:
  - the enum typedef of the FSM states (IDLE, PRESS_CNT, HELD, REL_CNT), logic [1:0];
  - localparam bit indices KEY_LOADA=0, KEY_LOADB=1, KEY_EXECUTE=2;
  - the default DEBOUNCE_CYCLES.
- Sub-module key_debounce_ch contains one channel: its synchronizer, FSM, counter, level output and pulse output. The top level instantiates it three times.

## Test plan
- Reset with Key_n=3'b111, DEBOUNCE_CYCLES=4: all outputs 0. Hold Key_n[0]=0 from edge 10: LoadA rises at edge 16 and Press=3'b001 only on edge 16.
- Bounce Key_n[2] low 3 cycles, high 1, low 3, high (DEBOUNCE_CYCLES=4): Execute and Press[2] stay 0 throughout.
- Release: with LoadB held, raise Key_n[1] at edge 40: LoadB falls at edge 46 and Press stays 0. A 2-cycle glitch back to released while held leaves LoadB at 1.
- Press all three keys at edge 20: all levels rise at edge 26 and Press=3'b111 for one cycle.
- Assert Reset at edge 14 during a LoadA press count: outputs go to 0 immediately. Key still held when reset is released at edge 15: LoadA rises at edge 21.
- KEY_COND_DEBOUNCE_EN undefined: a press at edge 10 gives a level at edge 13, and a 1-cycle glitch propagates as a 1-cycle level pulse.

Source files
------------

// File: rtl/key_cond_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
//
// Shared definitions for the push-button conditioning front end of the 4-bit
// logic processor: channel state encoding, bit positions of each button in the
// Key_n / Press vectors, and the default debounce window.
// -----------------------------------------------------------------------------
package key_cond_pkg;

    // 10 ms at a 50 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Bit positions shared by Key_n and Press.
    localparam int KEY_LOADA   = 0;
    localparam int KEY_LOADB   = 1;
    localparam int KEY_EXECUTE = 2;
    localparam int NUM_KEYS    = 3;

    // Per-channel debounce states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,   // stable released
        PRESS_CNT = 2'd1,   // candidate press, counting stable cycles
        HELD      = 2'd2,   // stable pressed
        REL_CNT   = 2'd3    // candidate release, counting stable cycles
    } key_state_t;

    // The debounced level is high in both "pressed" states, so a release
    // candidate keeps the level up until it is confirmed.
    function automatic logic state_is_pressed(input key_state_t s);
        return (s == HELD) || (s == REL_CNT);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//
// One button channel: two-flop synchronizer on the inverted (active-low) raw
// input, followed by either a counting debounce FSM (KEY_COND_DEBOUNCE_EN
// defined) or a single register stage (KEY_COND_DEBOUNCE_EN undefined, fast
// simulation builds only).
//
// Configuration macro: KEY_COND_DEBOUNCE_EN
//
// Parameters (debounce build only):
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change
//   CNT_W            counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   Clk    in   system clock
//   Reset  in   asynchronous, active-high reset
//   key_n  in   raw button, active-low, asynchronous to Clk
//   level  out  registered debounced level, high while pressed
//   press  out  registered one-cycle pulse on each debounced rising edge
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_cond_pkg::*;
`ifdef KEY_COND_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
)
`endif
(
    input  logic Clk,
    input  logic Reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    logic sync1;
    logic sync2;

    // The raw button is inverted before the first flop so everything past
    // the synchronizer works in active-high "pressed" terms.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
        end
    end

`ifdef KEY_COND_DEBOUNCE_EN

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    key_state_t       state;
    key_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             press_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            press <= press_next;
        end
    end

    // Any reversal of sync2 during a count drops back to the stable state
    // and clears the counter, so a bounce shorter than the window can never
    // move the level. Entering a counting state loads 1 because the cycle
    // that triggered the entry already counts as the first stable sample;
    // the count therefore tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;

        case (state)
            IDLE: begin
                if (sync2) begin
                    state_next = PRESS_CNT;
                    cnt_next   = CNT_ONE;
                end
            end

            PRESS_CNT: begin
                if (!sync2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            HELD: begin
                if (!sync2) begin
                    state_next = REL_CNT;
                    cnt_next   = CNT_ONE;
                end
            end

            REL_CNT: begin
                if (sync2) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so the level and the pulse
    // change on the same edge the FSM enters/leaves the pressed states. A
    // cancelled release (REL_CNT -> HELD) must not pulse, hence the explicit
    // PRESS_CNT origin.
    always_comb begin
        level_next = state_is_pressed(state_next);
        press_next = (state == PRESS_CNT) && (state_next == HELD);
    end

`else

    logic level_next;
    logic press_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            level <= level_next;
            press <= press_next;
        end
    end

    // Without debouncing the level simply follows sync2 one edge later and
    // every rise of it, however short, still produces a press pulse.
    always_comb begin
        level_next = sync2;
        press_next = sync2 && !level;
    end

`endif

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Front-end conditioning for the three push buttons of the 4-bit logic
// processor (LoadA, LoadB, Execute). Each button is handled by an independent
// key_debounce_ch channel; there is no priority or interaction between them.
// The level outputs feed the control FSM directly.
//
// Configuration macro: KEY_COND_DEBOUNCE_EN
//   defined   : full counting debounce, latency DEBOUNCE_CYCLES+2 edges
//   undefined : debounce compiled out, latency 3 edges (fast simulation only)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change, 2..2^24
//   CNT_W            derived counter width; leave at its default
//
// Ports:
//   Clk      in   system clock
//   Reset    in   asynchronous, active-high reset
//   Key_n    in   [2:0] raw buttons, active-low; 0=LoadA 1=LoadB 2=Execute
//   LoadA    out  debounced level of LoadA
//   LoadB    out  debounced level of LoadB
//   Execute  out  debounced level of Execute
//   Press    out  [2:0] one-cycle pulse per debounced rising edge, as Key_n
// -----------------------------------------------------------------------------
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] Key_n,
    output logic                LoadA,
    output logic                LoadB,
    output logic                Execute,
    output logic [NUM_KEYS-1:0] Press
);

    logic [NUM_KEYS-1:0] level;

    // Guards against an out-of-range window or an overridden counter width;
    // either would let the counter wrap or never reach its terminal value.
    assert property (@(posedge Clk) disable iff (Reset)
        (DEBOUNCE_CYCLES >= 2) && (DEBOUNCE_CYCLES <= 16777216) &&
        (CNT_W == $clog2(DEBOUNCE_CYCLES + 1)));

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
`ifdef KEY_COND_DEBOUNCE_EN
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .Clk   (Clk),
            .Reset (Reset),
            .key_n (Key_n[i]),
            .level (level[i]),
            .press (Press[i])
        );
`else
        key_debounce_ch u_ch (
            .Clk   (Clk),
            .Reset (Reset),
            .key_n (Key_n[i]),
            .level (level[i]),
            .press (Press[i])
        );
`endif
    end

    assign LoadA   = level[KEY_LOADA];
    assign LoadB   = level[KEY_LOADB];
    assign Execute = level[KEY_EXECUTE];

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4. A behavioural
// model (level flips once sync2 has disagreed with it for the whole window)
// produces the expected outputs for every edge; they are queued at each edge
// and popped/compared 1 time unit later. Edge-exact directed checks from the
// test plan are added on top. Works with and without KEY_COND_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int DEB = 4;
`ifdef KEY_COND_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 3;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Key_n;
    logic       LoadA;
    logic       LoadB;
    logic       Execute;
    logic [2:0] Press;

    int checks = 0;
    int errors = 0;
    int edgeNum = 0;

    // Model state: sync pipeline, levels, pulses, per-key run lengths.
    logic [2:0] mS1;
    logic [2:0] mS2;
    logic [2:0] mLevel;
    logic [2:0] mPress;
    int         mRun [3];

    // Scoreboard entries are {level[2:0], press[2:0]}.
    logic [5:0] expQ [$];

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Key_n   (Key_n),
        .LoadA   (LoadA),
        .LoadB   (LoadB),
        .Execute (Execute),
        .Press   (Press)
    );

    always #5 Clk = ~Clk;

    task automatic modelClear();
        mS1    = 3'b000;
        mS2    = 3'b000;
        mLevel = 3'b000;
        mPress = 3'b000;
        for (int i = 0; i < 3; i++) mRun[i] = 0;
    endtask

    task automatic modelEdge();
        if (Reset) begin
            modelClear();
        end else begin
            mPress = 3'b000;
            for (int i = 0; i < 3; i++) begin
`ifdef KEY_COND_DEBOUNCE_EN
                if (mS2[i] != mLevel[i]) begin
                    mRun[i]++;
                    if (mRun[i] == DEB) begin
                        mLevel[i] = ~mLevel[i];
                        mRun[i]   = 0;
                        mPress[i] = mLevel[i];
                    end
                end else begin
                    mRun[i] = 0;
                end
`else
                mPress[i] = mS2[i] & ~mLevel[i];
                mLevel[i] = mS2[i];
`endif
            end
            mS2 = mS1;
            mS1 = ~Key_n;
        end
    endtask

    task automatic checkValue(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, edgeNum, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [5:0] e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty edge=%0d observed=0 expected=1", edgeNum);
        end else begin
            e = expQ.pop_front();
            checkValue("levels", {Execute, LoadB, LoadA}, e[5:3]);
            checkValue("press", Press, e[2:0]);
        end
    endtask

    // Drives Key_n for the given number of edges, queuing the model's
    // expectation at each edge and comparing shortly after it.
    task automatic applyStimulus(input logic [2:0] keys, input int cycles);
        Key_n = keys;
        for (int c = 0; c < cycles; c++) begin
            @(posedge Clk);
            edgeNum++;
            modelEdge();
            expQ.push_back({mLevel, mPress});
            #1;
            checkOutput();
        end
    endtask

    // Asserts Reset between edges; outputs must clear without a clock edge.
    task automatic asyncReset();
        #2;
        Reset = 1'b1;
        #1;
        modelClear();
        checkValue("async_reset_levels", {Execute, LoadB, LoadA}, 3'b000);
        checkValue("async_reset_press", Press, 3'b000);
    endtask

    initial begin
        Reset = 1'b1;
        Key_n = 3'b111;
        modelClear();

        // Reset state.
        applyStimulus(3'b111, 2);
        checkValue("reset_levels", {Execute, LoadB, LoadA}, 3'b000);
        checkValue("reset_press", Press, 3'b000);
        Reset   = 1'b0;
        edgeNum = 0;

        // LoadA press from edge 10.
        applyStimulus(3'b111, 10 - edgeNum);
        applyStimulus(3'b110, LAT - 1);
        checkValue("loada_before_latency", {2'b00, LoadA}, 3'b000);
        applyStimulus(3'b110, 1);
        checkValue("loada_rise", {2'b00, LoadA}, 3'b001);
        checkValue("loada_press_pulse", Press, 3'b001);
        applyStimulus(3'b110, 1);
        checkValue("loada_press_single", Press, 3'b000);

        // LoadB held, released at edge 40.
        applyStimulus(3'b111, 12);
        applyStimulus(3'b101, 40 - edgeNum);
        applyStimulus(3'b111, LAT - 1);
        checkValue("loadb_before_release", {2'b00, LoadB}, 3'b001);
        applyStimulus(3'b111, 1);
        checkValue("loadb_fall", {2'b00, LoadB}, 3'b000);
        checkValue("loadb_no_release_pulse", Press, 3'b000);

        // LoadB held with a 2-cycle release glitch.
        applyStimulus(3'b101, 2 * LAT);
        applyStimulus(3'b111, 2);
        applyStimulus(3'b101, LAT + 2);
`ifdef KEY_COND_DEBOUNCE_EN
        checkValue("loadb_glitch_ignored", {2'b00, LoadB}, 3'b001);
`endif
        applyStimulus(3'b111, LAT + 2);

`ifdef KEY_COND_DEBOUNCE_EN
        // Execute bounce shorter than the window.
        applyStimulus(3'b011, 3);
        applyStimulus(3'b111, 1);
        applyStimulus(3'b011, 3);
        applyStimulus(3'b111, LAT + 2);
        checkValue("execute_bounce_ignored", {Execute, 2'b00}, 3'b000);
`else
        // One-cycle glitch passes straight through as a one-cycle level.
        applyStimulus(3'b110, 1);
        applyStimulus(3'b111, 2);
        checkValue("glitch_level", {2'b00, LoadA}, 3'b001);
        checkValue("glitch_press", Press, 3'b001);
        applyStimulus(3'b111, 1);
        checkValue("glitch_level_end", {2'b00, LoadA}, 3'b000);
        applyStimulus(3'b111, 2);
`endif

        // All three keys together.
        applyStimulus(3'b000, LAT);
        checkValue("all_levels", {Execute, LoadB, LoadA}, 3'b111);
        checkValue("all_press", Press, 3'b111);
        applyStimulus(3'b000, 1);
        checkValue("all_press_single", Press, 3'b000);
        applyStimulus(3'b111, LAT + 2);

        // Reset while LoadA is fully held, key kept down through release.
        applyStimulus(3'b110, LAT + 1);
        asyncReset();
        applyStimulus(3'b110, 1);
        Reset = 1'b0;
        applyStimulus(3'b110, LAT - 1);
        checkValue("post_reset_before_latency", {2'b00, LoadA}, 3'b000);
        applyStimulus(3'b110, 1);
        checkValue("post_reset_rise", {2'b00, LoadA}, 3'b001);
        checkValue("post_reset_press", Press, 3'b001);

        // Reset during a press count; the partial count is lost.
        applyStimulus(3'b111, LAT + 2);
        applyStimulus(3'b110, 3);
        asyncReset();
        applyStimulus(3'b110, 1);
        Reset = 1'b0;
        applyStimulus(3'b110, LAT + 2);
        applyStimulus(3'b111, LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
